// File: rtl/vga_timing_pkg.sv
// Shared 1080p timing constants and receiver state type for the VGA source/sink pair.
package vga_timing_pkg;

    localparam int unsigned C_HV  = 1920;
    localparam int unsigned C_HFP = 88;
    localparam int unsigned C_HSP = 44;
    localparam int unsigned C_HBP = 148;
    localparam int unsigned C_VV  = 1080;
    localparam int unsigned C_VFP = 4;
    localparam int unsigned C_VSP = 5;
    localparam int unsigned C_VBP = 36;

    localparam int unsigned C_HTOT = C_HV + C_HFP + C_HSP + C_HBP; // 2200
    localparam int unsigned C_VTOT = C_VV + C_VFP + C_VSP + C_VBP; // 1125

    localparam int unsigned C_CNT_W = 12;

    typedef enum logic [1:0] {
        StSearch,
        StTrack,
        StLocked
    } vga_rx_state_t;

endpackage

// File: rtl/vga_pos_counter.sv
// Horizontal/vertical raster position counters with per-cycle load and wrap.
// The current position (o_h/o_v) already reflects a load issued this cycle, so
// a loaded value pairs with the sample that triggered the load.
module vga_pos_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned HTOT = C_HTOT,
    parameter int unsigned VTOT = C_VTOT,
    parameter int unsigned W    = C_CNT_W
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_h_load,
    input  logic [W-1:0] i_h_load_val,
    input  logic         i_v_load,
    input  logic [W-1:0] i_v_load_val,
    output logic [W-1:0] o_h,
    output logic [W-1:0] o_v
);

    logic [W-1:0] r_h;
    logic [W-1:0] r_v;
    logic [W-1:0] w_h;
    logic [W-1:0] w_v;
    logic [W-1:0] w_h_nxt;
    logic [W-1:0] w_v_nxt;
    logic         w_h_wrap;

    // Current horizontal position and its successor.
    always_comb begin
        w_h      = i_h_load ? i_h_load_val : r_h;
        w_h_wrap = (w_h == W'(HTOT - 1));
        w_h_nxt  = w_h_wrap ? '0 : w_h + 1'b1;
    end

    // Current vertical position; advances only when the line wraps.
    always_comb begin
        w_v     = i_v_load ? i_v_load_val : r_v;
        w_v_nxt = w_v;
        if (w_h_wrap) begin
            w_v_nxt = (w_v == W'(VTOT - 1)) ? '0 : w_v + 1'b1;
        end
    end

    // Position registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            r_h <= w_h_nxt;
            r_v <= w_v_nxt;
        end
    end

    assign o_h = w_h;
    assign o_v = w_v;

endmodule

// File: rtl/vga_sync_rx.sv
// VGA timing receiver: aligns to incoming syncs, checks them against nominal
// timing, locks after clean frames and emits a per-pixel coordinate/colour stream.
module vga_sync_rx
    import vga_timing_pkg::*;
#(
    parameter int unsigned HV          = C_HV,
    parameter int unsigned HFP         = C_HFP,
    parameter int unsigned HSP         = C_HSP,
    parameter int unsigned HBP         = C_HBP,
    parameter int unsigned VV          = C_VV,
    parameter int unsigned VFP         = C_VFP,
    parameter int unsigned VSP         = C_VSP,
    parameter int unsigned VBP         = C_VBP,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned RGB_LAG     = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [3:0]  i_red,
    input  logic [3:0]  i_green,
    input  logic [3:0]  i_blue,
    output logic        o_locked,
    output logic        o_pix_valid,
    output logic [11:0] o_pix_x,
    output logic [11:0] o_pix_y,
    output logic [11:0] o_pix_rgb,
    output logic        o_frame_start,
    output logic        o_timing_err,
    output logic [15:0] o_err_count
);

    localparam int unsigned HTOT = HV + HFP + HSP + HBP;
    localparam int unsigned VTOT = VV + VFP + VSP + VBP;

    localparam logic [11:0] L_HV       = 12'(HV);
    localparam logic [11:0] L_VV       = 12'(VV);
    localparam logic [11:0] L_HS_BEG   = 12'(HV + HFP);
    localparam logic [11:0] L_HS_END   = 12'(HV + HFP + HSP);
    localparam logic [11:0] L_VS_BEG   = 12'(VV + VFP);
    localparam logic [11:0] L_VS_END   = 12'(VV + VFP + VSP);
    localparam logic [3:0]  L_LOCK_CNT = 4'(LOCK_FRAMES);

    // Stage 1 and previous-sample registers
    logic        r_hs1;
    logic        r_vs1;
    logic        r_hs1_prev;
    logic        r_vs1_prev;
    logic [11:0] r_rgb1;
    logic        w_hs_fall;
    logic        w_vs_fall;

    // Position tracking
    logic        w_h_load;
    logic        w_v_load;
    logic [11:0] w_cur_h;
    logic [11:0] w_cur_v;
    logic        w_hs_exp;
    logic        w_vs_exp;
    logic        w_mismatch;

    // Control state
    vga_rx_state_t r_state;
    vga_rx_state_t w_state_d;
    logic          r_h_aligned;
    logic          w_h_aligned_d;
    logic [3:0]    r_good;
    logic [3:0]    w_good_d;
    logic [3:0]    w_good_inc;
    logic          w_err_d;
    logic          w_lock_d;

    // Stage 2 outputs
    logic        r_locked;
    logic        r_pix_valid;
    logic [11:0] r_pix_x;
    logic [11:0] r_pix_y;
    logic        r_frame_start;
    logic        r_timing_err;
    logic [15:0] r_err_count;

    // Stage 1: capture pins; syncs reset to their idle (high) level so no false edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hs1      <= 1'b1;
            r_vs1      <= 1'b1;
            r_hs1_prev <= 1'b1;
            r_vs1_prev <= 1'b1;
            r_rgb1     <= '0;
        end else begin
            r_hs1      <= i_hsync;
            r_vs1      <= i_vsync;
            r_hs1_prev <= r_hs1;
            r_vs1_prev <= r_vs1;
            r_rgb1     <= {i_red, i_green, i_blue};
        end
    end

    assign w_hs_fall = r_hs1_prev & ~r_hs1;
    assign w_vs_fall = r_vs1_prev & ~r_vs1;

    // Realignment happens only while searching; tracking never lets edges move the counters.
    assign w_h_load = (r_state == StSearch) && w_hs_fall;
    assign w_v_load = (r_state == StSearch) && w_vs_fall && r_h_aligned && (w_cur_h == '0);

    vga_pos_counter #(
        .HTOT (HTOT),
        .VTOT (VTOT),
        .W    (12)
    ) u_pos (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_h_load     (w_h_load),
        .i_h_load_val (L_HS_BEG),
        .i_v_load     (w_v_load),
        .i_v_load_val (L_VS_BEG),
        .o_h          (w_cur_h),
        .o_v          (w_cur_v)
    );

    assign w_hs_exp   = !((w_cur_h >= L_HS_BEG) && (w_cur_h < L_HS_END));
    assign w_vs_exp   = !((w_cur_v >= L_VS_BEG) && (w_cur_v < L_VS_END));
    assign w_mismatch = (r_hs1 != w_hs_exp) || (r_vs1 != w_vs_exp);
    assign w_good_inc = r_good + 4'd1;

    // Next-state logic: search/align, count clean frames, drop lock on mismatch.
    always_comb begin
        w_state_d     = r_state;
        w_h_aligned_d = r_h_aligned;
        w_good_d      = r_good;
        w_err_d       = 1'b0;
        unique case (r_state)
            StSearch: begin
                if (w_hs_fall) begin
                    w_h_aligned_d = 1'b1;
                end
                if (w_v_load) begin
                    w_good_d  = '0;
                    w_state_d = StTrack;
                end
            end
            StTrack: begin
                if (w_mismatch) begin
                    w_state_d     = StSearch;
                    w_h_aligned_d = 1'b0;
                end else if (w_vs_fall) begin
                    w_good_d = w_good_inc;
                    if (w_good_inc == L_LOCK_CNT) begin
                        w_state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                if (w_mismatch) begin
                    w_state_d     = StSearch;
                    w_h_aligned_d = 1'b0;
                    w_err_d       = 1'b1;
                end
            end
            default: begin
                w_state_d     = StSearch;
                w_h_aligned_d = 1'b0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StSearch;
            r_h_aligned <= 1'b0;
            r_good      <= '0;
        end else begin
            r_state     <= w_state_d;
            r_h_aligned <= w_h_aligned_d;
            r_good      <= w_good_d;
        end
    end

    // Outputs use next state so lock changes land two cycles after the pin sample.
    assign w_lock_d = (w_state_d == StLocked);

    // Stage 2: registered pixel stream, lock and error reporting.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_locked      <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_frame_start <= 1'b0;
            r_timing_err  <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_locked      <= w_lock_d;
            r_pix_valid   <= w_lock_d && (w_cur_h < L_HV) && (w_cur_v < L_VV);
            r_pix_x       <= w_cur_h;
            r_pix_y       <= w_cur_v;
            r_frame_start <= w_lock_d && (w_cur_h == '0) && (w_cur_v == '0);
            r_timing_err  <= w_err_d;
            if (w_err_d && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    // Colour arriving RGB_LAG cycles after its sync needs that many fewer register stages.
    if (RGB_LAG == 0) begin : g_rgb_stage2
        logic [11:0] r_rgb2;

        // Extra colour stage to match the coordinate pipeline.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_rgb2 <= '0;
            end else begin
                r_rgb2 <= r_rgb1;
            end
        end

        assign o_pix_rgb = r_rgb2;
    end else begin : g_rgb_stage1
        assign o_pix_rgb = r_rgb1;
    end

    assign o_locked      = r_locked;
    assign o_pix_valid   = r_pix_valid;
    assign o_pix_x       = r_pix_x;
    assign o_pix_y       = r_pix_y;
    assign o_frame_start = r_frame_start;
    assign o_timing_err  = r_timing_err;
    assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx at reduced timing with a looped-back generator model.
`timescale 1ns/1ps
module tb_vga_sync_rx;

    localparam int HTOT   = 24;
    localparam int VTOT   = 12;
    localparam int HS_BEG = 18;
    localparam int HS_END = 21;
    localparam int VS_BEG = 9;
    localparam int VS_END = 11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [3:0]  red = '0;
    logic [3:0]  green = '0;
    logic [3:0]  blue = '0;
    logic        o_locked;
    logic        o_pix_valid;
    logic [11:0] o_pix_x;
    logic [11:0] o_pix_y;
    logic [11:0] o_pix_rgb;
    logic        o_frame_start;
    logic        o_timing_err;
    logic [15:0] o_err_count;

    int checks = 0;
    int errors = 0;

    // Generator position of the pixel whose sync is currently on the pins.
    int g_h = HTOT - 1;
    int g_v = VTOT - 1;
    int g_frame = -1;
    int long_f = -1;
    int long_v = -1;
    int early_f = -1;

    int tot_valid = 0;
    int tot_fs = 0;
    int pair_bad = 0;
    int fs_bad = 0;
    int v0;
    int fs0;

    always #5 clk = ~clk;

    vga_sync_rx #(
        .HV          (16),
        .HFP         (2),
        .HSP         (3),
        .HBP         (3),
        .VV          (8),
        .VFP         (1),
        .VSP         (2),
        .VBP         (1),
        .LOCK_FRAMES (2),
        .RGB_LAG     (1)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_hsync       (hsync),
        .i_vsync       (vsync),
        .i_red         (red),
        .i_green       (green),
        .i_blue        (blue),
        .o_locked      (o_locked),
        .o_pix_valid   (o_pix_valid),
        .o_pix_x       (o_pix_x),
        .o_pix_y       (o_pix_y),
        .o_pix_rgb     (o_pix_rgb),
        .o_frame_start (o_frame_start),
        .o_timing_err  (o_timing_err),
        .o_err_count   (o_err_count)
    );

    // Stream monitor: pixel counts, colour pairing and frame_start placement.
    always @(negedge clk) begin
        if (o_pix_valid) begin
            tot_valid <= tot_valid + 1;
            if (o_pix_rgb !== {4'h0, o_pix_x[3:0], o_pix_y[3:0]}) pair_bad <= pair_bad + 1;
        end
        if (o_frame_start) begin
            tot_fs <= tot_fs + 1;
            if (!o_pix_valid || o_pix_x != '0 || o_pix_y != '0) fs_bad <= fs_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the generator one pixel; colour trails sync by one cycle.
    task automatic tick();
        int ph;
        int pv;
        @(posedge clk);
        #1;
        ph = g_h;
        pv = g_v;
        if (g_h == HTOT - 1) begin
            g_h = 0;
            if (g_v == VTOT - 1) begin
                g_v = 0;
                g_frame++;
            end else begin
                g_v++;
            end
        end else begin
            g_h++;
        end
        hsync = !((g_h >= HS_BEG && g_h < HS_END) ||
                  (g_frame == long_f && g_v == long_v && g_h == HS_END));
        vsync = !((g_v >= VS_BEG && g_v < VS_END) || (g_frame == early_f && g_v == VS_BEG - 1));
        red   = 4'h0;
        green = ph[3:0];
        blue  = pv[3:0];
    endtask

    task automatic step2();
        tick();
        tick();
    endtask

    task automatic run_to(input int f, input int v, input int h);
        int n;
        n = 0;
        while (!(g_frame == f && g_v == v && g_h == h)) begin
            tick();
            n++;
            if (n > 5000) begin
                errors++;
                $display("FAIL run_to_timeout: observed frame %0d line %0d expected frame %0d",
                         g_frame, g_v, f);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "generator position never reached");
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({o_locked, o_pix_valid, o_frame_start, o_timing_err,
              o_pix_x, o_pix_y, o_pix_rgb}), 64'd0);
        check("reset_err_count", 64'(o_err_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Clean stream: aligned in frame 0, lock on frame 2 Vsync fall.
        run_to(1, 9, 0);
        step2();
        check("no_lock_f1", 64'(o_locked), 64'd0);
        run_to(2, 9, 0);
        tick();
        check("lock_rise_minus1", 64'(o_locked), 64'd0);
        tick();
        check("lock_rise", 64'(o_locked), 64'd1);
        check("err_count_clean", 64'(o_err_count), 64'd0);

        run_to(3, 0, 0);
        v0 = tot_valid;
        fs0 = tot_fs;
        run_to(3, 3, 5);
        step2();
        check("pix_5_3_xy", 64'({o_pix_x, o_pix_y}), 64'({12'd5, 12'd3}));
        check("pix_5_3_rgb", 64'(o_pix_rgb), 64'h053);
        check("pix_5_3_valid", 64'(o_pix_valid), 64'd1);
        run_to(3, 3, 16);
        step2();
        check("x_edge_invalid", 64'(o_pix_valid), 64'd0);
        run_to(3, 7, 15);
        step2();
        check("last_pix_valid", 64'(o_pix_valid), 64'd1);
        check("last_pix_rgb", 64'({o_pix_x, o_pix_y, o_pix_rgb}),
              64'({12'd15, 12'd7, 12'h0F7}));
        run_to(3, 8, 0);
        step2();
        check("y_edge_invalid", 64'(o_pix_valid), 64'd0);
        run_to(4, 0, 0);
        check("valid_per_frame", 64'(tot_valid - v0), 64'd128);
        check("fs_per_frame", 64'(tot_fs - fs0), 64'd1);
        check("rgb_pairing", 64'(pair_bad), 64'd0);
        check("fs_position", 64'(fs_bad), 64'd0);

        // One 4-cycle Hsync while locked.
        long_f = 4;
        long_v = 2;
        run_to(4, 2, 21);
        tick();
        check("long_hs_pre", 64'({o_locked, o_timing_err}), 64'b10);
        tick();
        check("long_hs_err", 64'({o_locked, o_timing_err}), 64'b01);
        check("long_hs_count", 64'(o_err_count), 64'd1);
        tick();
        check("long_hs_pulse_end", 64'(o_timing_err), 64'd0);
        run_to(5, 9, 0);
        step2();
        check("relock1_early", 64'(o_locked), 64'd0);
        run_to(6, 9, 0);
        step2();
        check("relock1", 64'(o_locked), 64'd1);

        // Vsync one line early while locked.
        early_f = 7;
        run_to(7, 8, 0);
        tick();
        check("early_vs_pre", 64'(o_timing_err), 64'd0);
        tick();
        check("early_vs_err", 64'({o_locked, o_timing_err}), 64'b01);
        check("early_vs_count", 64'(o_err_count), 64'd2);
        run_to(8, 3, 5);
        step2();
        check("valid_low_unlocked", 64'(o_pix_valid), 64'd0);
        run_to(9, 9, 0);
        step2();
        check("relock2_early", 64'(o_locked), 64'd0);
        run_to(10, 9, 0);
        step2();
        check("relock2", 64'(o_locked), 64'd1);

        // Reset pulse mid-frame while locked.
        run_to(11, 4, 10);
        reset = 1'b1;
        #1;
        check("midreset_clear", 64'({o_locked, o_pix_valid, o_frame_start, o_timing_err,
              o_pix_x, o_pix_y, o_pix_rgb}), 64'd0);
        check("midreset_err_count", 64'(o_err_count), 64'd0);
        step2();
        check("midreset_hold", 64'({o_locked, o_pix_valid, o_pix_x, o_pix_y}), 64'd0);
        reset = 1'b0;
        run_to(12, 9, 0);
        step2();
        check("relock3_early", 64'(o_locked), 64'd0);
        run_to(13, 9, 0);
        step2();
        check("relock3", 64'(o_locked), 64'd1);

        // Saturation: preload the counter, then inject one more error.
        run_to(14, 1, 0);
        force dut.r_err_count = 16'hFFFF;
        tick();
        release dut.r_err_count;
        long_f = 14;
        long_v = 2;
        run_to(14, 2, 21);
        step2();
        check("sat_err_pulse", 64'({o_locked, o_timing_err}), 64'b01);
        check("sat_err_count", 64'(o_err_count), 64'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

Sink-side VGA timing receiver: it samples a VGA stream (Hsync, Vsync, 4:4:4 RGB) in the pixel-clock domain and recovers the pixel coordinates. It checks every sync sample against the nominal 1080p timing, declares lock after consecutive clean frames, and emits a per-pixel stream (valid, x, y, rgb) for capture or checker logic. It sits on the loopback/capture path facing the team's VGA timing generator.

## Interface
- HV, HFP, HSP, HBP: 1920, 88, 44, 148. Horizontal visible, front porch, sync and back porch, in pixels.
- VV, VFP, VSP, VBP: 1080, 4, 5, 36. Vertical visible, front porch, sync and back porch, in lines.
- LOCK_FRAMES: 2. Consecutive clean frames required to lock. Range 1–15.
- RGB_LAG: 1. Cycles by which RGB trails sync for the same pixel. Range 0–1.
- clk  in  1  pixel clock, 148.5 MHz. This is the same clock that drives the source.
- reset  in  1  asynchronous, active-high.
- Hsync, Vsync  in  1  sync inputs, active low.
- red, green, blue  in  4 each  colour inputs.
- locked  out  1  timing lock flag.
- pix_valid  out  1  the output pixel is visible and `locked` is high.
- pix_x, pix_y  out  12 each  output pixel coordinates.
- pix_rgb  out  12  colour of the output pixel, packed {r,g,b}.
- frame_start  out  1  one-cycle pulse with pixel (0,0).
- timing_err  out  1  one-cycle pulse on a sync mismatch.
- err_count  out  16  count of `timing_err` pulses; saturates at 16'hFFFF.

## Operation
- Stage 1 registers Hsync, Vsync and RGB. All edge detection uses stage 1 against its previous value.
- Horizontal position `cur_h` (HTOT = sum of the horizontal parameters):
  - On an Hsync falling edge while in SEARCH: force `cur_h` = HV+HFP and set `h_aligned`.
  - Otherwise: increment `cur_h`, wrapping from HTOT-1 to 0.
- Vertical position `v`: increments when `cur_h` wraps, wrapping from VTOT-1 to 0.
- Expected levels:
  - Hsync is low iff HV+HFP ≤ `cur_h` < HV+HFP+HSP.
  - Vsync is low iff VV+VFP ≤ `v` < VV+VFP+VSP.
- FSM states are SEARCH, TRACK and LOCKED.
- SEARCH → TRACK: on a Vsync falling edge with `h_aligned`=1 and `cur_h`=0. On that transition, set `v` = VV+VFP and clear the good-frame counter. A Vsync fall that does not meet these conditions leaves the FSM in SEARCH.
- TRACK and LOCKED check every cycle. A mismatch is either sync sample differing from its expected level.
- TRACK:
  - A mismatch sends the FSM to SEARCH and clears `h_aligned`. No `timing_err` pulse.
  - Each Vsync fall increments the good-frame counter. When the counter reaches LOCK_FRAMES, go to LOCKED.
- LOCKED:
  - A mismatch sends the FSM to SEARCH, clears `h_aligned`, pulses `timing_err` and increments `err_count` (saturating).
- `h_aligned` is also set by the next Hsync falling edge seen in SEARCH.
- In TRACK and LOCKED, sync edges never realign the counters.
- Outputs (stage 2, registered):
  - `locked` = (state==LOCKED).
  - `pix_valid` = `locked` && x<HV && y<VV.
  - `frame_start` = `pix_valid` && x==0 && y==0.
  - With RGB_LAG=1, coordinates are delayed one cycle so that `pix_rgb` pairs with the correct pixel.
- Counter widths are 12 bits. The ranges are `cur_h` < HTOT ≤ 4095 and `v` < VTOT ≤ 4095.

## Timing
- Reset: every output is 0, state is SEARCH, `h_aligned`=0, counters are 0.
- Reset takes effect immediately, including mid-frame. Relock follows the full SEARCH → TRACK → LOCKED sequence.
- Latency: sync pins to `pix_x`/`pix_y`/`locked` is 2 cycles. RGB pins to `pix_rgb` is 2−RGB_LAG cycles.
- `locked` rises 2 cycles after the Vsync falling edge that completes LOCK_FRAMES clean frames.
- `locked` falls 2 cycles after the offending sync sample reaches the input pins.
- `timing_err` coincides with the cycle in which `locked` falls.
- Simultaneous Hsync and Vsync falls are legal. Vsync falls at `cur_h`=0 by design.

## Structure
- Shared package `vga_timing_pkg` holds:
  - the 1080p timing constants and derived HTOT (2200) and VTOT (1125);
  - a `vga_rx_state_t` enum for SEARCH, TRACK and LOCKED.
- The source generator uses the same package.
- One sub-module, `vga_pos_counter`: the `cur_h`/`v` counters with load and wrap, used by both the receiver and any future generator.

## Test plan
Benches use reduced timing (HV=16, HFP=2, HSP=3, HBP=3, giving HTOT=24; VV=8, VFP=1, VSP=2, VBP=1, giving VTOT=12; LOCK_FRAMES=2) with a matching generator looped back and RGB_LAG=1.

- Reset asserted → all outputs 0 on the next cycle; they remain 0 while reset is held.
- Clean stream from reset → `locked` rises on the second Vsync fall after the first aligned one. Each frame then has exactly 128 `pix_valid` cycles, and `frame_start` fires once per frame at (0,0).
- Generator RGB = {4'h0, x[3:0], y[3:0]} → `pix_rgb` = 12'h053 at `pix_x`=5, `pix_y`=3, on every pixel check.
- While locked, one line carries a 4-cycle Hsync → one `timing_err` pulse, `locked` drops, `err_count`=1. Relock follows after one aligning Vsync fall plus 2 clean frames.
- While locked, Vsync asserted one line early → `timing_err` pulse, `err_count` increments, `pix_valid` goes low.
- Reset pulsed mid-frame while locked → outputs clear within 1 cycle, then relock at the same frame count as the clean-stream case. Saturation case: force `err_count` to 16'hFFFF, inject an error → `err_count` holds at 16'hFFFF.
